// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_stage
//  Description : Fetch stage and IF/ID register. Owns the PC, handles
//                load-use stalls, ID jump redirects and EX branch flushes.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [5:0]  J_OPCODE = 6'h02
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        id_ex_memread,
   input  logic [4:0]  id_ex_rt,
   output logic [31:0] instr_out,
   output logic [31:0] pc_plus4_out,
   output logic        valid_out,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic        bubble,
   output logic        pc_write
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic        valid_q, valid_d;

   logic        w_is_jump;
   logic        w_stall;
   logic [31:0] w_pc_inc;
   logic [31:0] w_jump_target;

   assign opcode = instr_q[31:26];
   assign rs     = instr_q[25:21];
   assign rt     = instr_q[20:16];
   assign rd     = instr_q[15:11];

   // Every hazard term is qualified by valid, so a flushed slot or X data
   // never produces a stall or redirect.
   assign w_is_jump = valid_q && (opcode == J_OPCODE);
   assign w_stall   = valid_q && !w_is_jump && id_ex_memread &&
                      (id_ex_rt != 5'd0) && ((id_ex_rt == rs) || (id_ex_rt == rt));

   assign bubble        = w_stall && !branch_taken;
   assign pc_write      = !bubble;
   assign w_pc_inc      = pc_q + 32'd4;
   assign w_jump_target = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};

   assign imem_addr    = pc_q;
   assign instr_out    = instr_q;
   assign pc_plus4_out = pc_plus4_q;
   assign valid_out    = valid_q;

   always_comb begin
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      if (branch_taken) begin
         pc_d       = branch_target;
         instr_d    = 32'd0;
         pc_plus4_d = 32'd0;
         valid_d    = 1'b0;
      end else if (w_stall) begin
         pc_d = pc_q;
      end else if (w_is_jump) begin
         pc_d       = w_jump_target;
         instr_d    = 32'd0;
         pc_plus4_d = 32'd0;
         valid_d    = 1'b0;
      end else begin
         pc_d       = w_pc_inc;
         instr_d    = imem_data;
         pc_plus4_d = w_pc_inc;
         valid_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         instr_q    <= 32'd0;
         pc_plus4_q <= 32'd0;
         valid_q    <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_stage
//  Description : Self-checking bench for if_id_stage against a fetch model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [5:0]  J_OPCODE = 6'h02;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        id_ex_memread;
   logic [4:0]  id_ex_rt;
   logic [31:0] instr_out;
   logic [31:0] pc_plus4_out;
   logic        valid_out;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic        bubble;
   logic        pc_write;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state of the fetch unit
   logic [31:0] m_pc, m_instr, m_pp4;
   logic        m_valid;
   logic [31:0] mem [logic [31:0]];

   if_id_stage #(.RESET_PC(RESET_PC), .J_OPCODE(J_OPCODE)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
      .instr_out(instr_out), .pc_plus4_out(pc_plus4_out), .valid_out(valid_out),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
      .bubble(bubble), .pc_write(pc_write)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_3C3C;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: apply inputs, check decode/hazard outputs, clock, check state.
   task automatic step(input logic rst_v, input logic mr, input logic [4:0] ert,
                       input logic bt, input logic [31:0] tgt);
      logic        jmp, haz;
      logic [31:0] word;
      reset         = rst_v;
      id_ex_memread = mr;
      id_ex_rt      = ert;
      branch_taken  = bt;
      branch_target = tgt;
      word          = imem_word(m_pc);
      imem_data     = word;
      jmp = m_valid && (m_instr[31:26] == J_OPCODE);
      haz = m_valid && !jmp && mr && (ert != 5'd0) &&
            ((ert == m_instr[25:21]) || (ert == m_instr[20:16]));
      #1;
      chk("imem_addr", imem_addr, m_pc);
      chk("opcode", {26'd0, opcode}, {26'd0, m_instr[31:26]});
      chk("rs", {27'd0, rs}, {27'd0, m_instr[25:21]});
      chk("rt", {27'd0, rt}, {27'd0, m_instr[20:16]});
      chk("rd", {27'd0, rd}, {27'd0, m_instr[15:11]});
      chk("bubble", {31'd0, bubble}, {31'd0, haz && !bt});
      chk("pc_write", {31'd0, pc_write}, {31'd0, !(haz && !bt)});
      @(posedge clk);
      if (rst_v) begin
         m_pc = RESET_PC; m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0;
      end else if (bt) begin
         m_pc = tgt; m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0;
      end else if (haz) begin
         m_pc = m_pc;
      end else if (jmp) begin
         m_pc = {m_pp4[31:28], m_instr[25:0], 2'b00};
         m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0;
      end else begin
         m_instr = word; m_pp4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1'b1;
      end
      #1;
      chk("instr_out", instr_out, m_instr);
      chk("pc_plus4_out", pc_plus4_out, m_pp4);
      chk("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
      chk("pc", imem_addr, m_pc);
   endtask

   initial begin
      logic        r_mr, r_bt, r_rst;
      logic [4:0]  r_rt;
      logic [31:0] r_tgt;

      mem[32'h0000_0000] = 32'h2008_0005;
      mem[32'h0000_0004] = 32'h0109_5020;   // add $10,$8,$9
      mem[32'h0000_0008] = 32'h0000_5020;   // add $10,$0,$0
      mem[32'h0000_000C] = 32'h0800_0040;   // j 0x100
      mem[32'h0000_0100] = 32'h0109_5020;

      reset = 1'b1; imem_data = 32'd0; branch_taken = 1'b0; branch_target = 32'd0;
      id_ex_memread = 1'b0; id_ex_rt = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      m_pc = RESET_PC; m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0;
      chk("rst_imem_addr", imem_addr, 32'h0000_0000);
      chk("rst_instr", instr_out, 32'd0);
      chk("rst_valid", {31'd0, valid_out}, 32'd0);
      chk("rst_bubble", {31'd0, bubble}, 32'd0);
      chk("rst_pc_write", {31'd0, pc_write}, 32'd1);

      // Sequential fetch from reset: 0, 4, 8
      step(0, 0, 0, 0, 0);
      chk("first_instr", instr_out, 32'h2008_0005);
      chk("first_pp4", pc_plus4_out, 32'h0000_0004);
      step(0, 0, 0, 0, 0);
      chk("addr_8", imem_addr, 32'h0000_0008);
      // Load-use on rs=8, held twice (back-to-back), then resume
      step(0, 1, 5'd8, 0, 0);
      chk("stall_pc_hold", imem_addr, 32'h0000_0008);
      chk("stall_instr_hold", instr_out, 32'h0109_5020);
      step(0, 1, 5'd8, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("resume_pc", imem_addr, 32'h0000_000C);
      // Load to $0 never stalls
      step(0, 1, 5'd0, 0, 0);
      chk("jump_in_ifid", instr_out, 32'h0800_0040);
      // Jump redirect
      step(0, 0, 0, 0, 0);
      chk("jump_pc", imem_addr, 32'h0000_0100);
      chk("jump_flush", {31'd0, valid_out}, 32'd0);
      step(0, 0, 0, 0, 0);
      chk("post_jump_instr", instr_out, 32'h0109_5020);
      // Branch overrides an active stall
      step(0, 1, 5'd9, 1, 32'h0000_0200);
      chk("branch_pc", imem_addr, 32'h0000_0200);
      chk("branch_flush", {31'd0, valid_out}, 32'd0);
      // PC wrap, then reset beats a branch
      step(0, 0, 0, 1, 32'hFFFF_FFFC);
      step(0, 0, 0, 0, 0);
      chk("wrap_pc", imem_addr, 32'h0000_0000);
      step(1, 0, 0, 1, 32'h0000_0300);
      chk("rst_over_branch", imem_addr, RESET_PC);

      for (int i = 0; i < 400; i++) begin
         r_rst = ($urandom_range(0, 59) == 0);
         r_bt  = ($urandom_range(0, 7) == 0);
         r_mr  = $urandom_range(0, 1) == 1;
         r_rt  = ($urandom_range(0, 1) == 1) ? m_instr[25:21] + 5'($urandom_range(0, 1))
                                             : 5'($urandom_range(0, 31));
         r_tgt = {$urandom} & 32'hFFFF_FFFC;
         step(r_rst, r_mr, r_rt, r_bt, r_tgt);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch stage plus IF/ID pipeline register. It sits directly upstream of the ID/EX register.
- Owns the program counter and drives the instruction-memory address.
- Latches the fetched instruction and PC+4 for decode, and splits out the opcode/rs/rt/rd fields.
- Performs load-use hazard detection (stall plus bubble), J-type redirect from ID, and branch redirect/flush from EX.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
J_OPCODE, 6'h02, opcode decoded as unconditional jump

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
imem_addr  output  32  instruction memory address (= PC register)
imem_data  input  32  instruction word at imem_addr, combinational read, valid same cycle
branch_taken  input  1  EX stage resolved a taken branch this cycle
branch_target  input  32  target PC for branch_taken
id_ex_memread  input  1  MemRead currently held in ID/EX
id_ex_rt  input  5  rt currently held in ID/EX
instr_out  output  32  IF/ID instruction
pc_plus4_out  output  32  IF/ID PC+4
valid_out  output  1  IF/ID holds a real instruction
opcode  output  6  instr_out[31:26]
rs  output  5  instr_out[25:21]
rt  output  5  instr_out[20:16]
rd  output  5  instr_out[15:11]
bubble  output  1  ID must inject zero controls into ID/EX this cycle
pc_write  output  1  PC updates at next edge (debug/visibility)

Behaviour:
- State:
  - pc (32)
  - IF/ID: instr (32), pc_plus4 (32), valid (1)
- Reset (synchronous, wins over everything):
  - pc <= RESET_PC.
  - instr, pc_plus4 <= 0; valid <= 0.
  - Consequences: opcode/rs/rt/rd = 0, bubble = 0, imem_addr = RESET_PC, pc_write = 1.
- Combinational decode from IF/ID:
  - is_jump = valid && opcode == J_OPCODE.
  - stall = valid && !is_jump && id_ex_memread && id_ex_rt != 0 && (id_ex_rt == rs || id_ex_rt == rt).
  - bubble = stall && !branch_taken.
  - pc_write = !bubble.
- Next-state priority, evaluated each rising edge when reset is low:
  1. branch_taken:
     - pc <= branch_target.
     - IF/ID flushed: instr <= 0, valid <= 0, pc_plus4 <= 0.
     - Overrides stall and jump, because the wrong-path instruction in ID is discarded.
  2. stall:
     - pc holds.
     - IF/ID holds all fields.
     - bubble = 1 for that cycle.
  3. is_jump:
     - pc <= {pc_plus4[31:28], instr[25:0], 2'b00}.
     - IF/ID flushed: valid <= 0, instr <= 0, pc_plus4 <= 0. This kills the sequential fetch after the jump, giving a 1-cycle penalty.
  4. Default:
     - pc <= pc + 4, with 32-bit wrap (32'hFFFF_FFFC -> 0).
     - instr <= imem_data, pc_plus4 <= pc + 4, valid <= 1.
- Latency:
  - The word at PC p in cycle n appears on instr_out after edge n+1.
  - Branch redirect penalty: 2 cycles (EX resolution). Jump penalty: 1 cycle.
- Stall persistence:
  - A load-use stall lasts exactly as long as the condition holds, normally 1 cycle, because upstream ID/EX receives the bubble.
  - Back-to-back stalls are permitted.
- Flushed slot: instr = 0 (NOP, sll $0), valid = 0. A flushed slot never raises stall or is_jump.
- Reset mid-stall or mid-redirect: reset wins, and state returns to reset values on that edge.
- No X propagation: an unknown imem_data is latched only into instr; control outputs depend only on valid-qualified decode.

Test Plan:
- Reset then release, imem returns 32'h2008_0005 at 0:
  - imem_addr sequence is 0, 4, 8.
  - After the 1st post-reset edge, instr_out = 32'h2008_0005, pc_plus4_out = 4, valid_out = 1.
- Load-use: id_ex_memread = 1, id_ex_rt = 8, IF/ID holds add with rs = 8 (32'h0109_5020):
  - bubble = 1 and pc_write = 0.
  - pc and instr_out are unchanged for 1 cycle.
  - After memread deasserts, fetch resumes at pc+4.
- Load to $0: id_ex_rt = 0, matching rs = 0:
  - No stall, bubble = 0.
- Jump: IF/ID holds 32'h0800_0040 with pc_plus4 = 32'h0000_0010:
  - Next pc = 32'h0000_0100.
  - IF/ID becomes valid = 0, instr = 0.
  - Next fetched instr is from address 0x100.
- Branch while stalled: stall active and branch_taken = 1, branch_target = 32'h0000_0200:
  - bubble = 0.
  - pc = 0x200, IF/ID flushed (valid = 0).
- Wrap and reset priority: pc = 32'hFFFF_FFFC with default advance gives pc = 0. Asserting reset together with branch_taken gives pc = RESET_PC and valid = 0.
